// File: rtl/fft8_out_serializer.sv
// fft8_out_serializer
// Captures the eight complex results of the last butterfly stage, removes the
// Q8 scaling with round-half-up, and streams the bins out in natural frequency
// order over a valid/ready handshake.
module fft8_out_serializer #(
  parameter int DATA_W = 32,
  parameter int SHIFT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              butterfly3_done,
  input  logic [DATA_W-1:0] fft_d1_real,
  input  logic [DATA_W-1:0] fft_d1_imag,
  input  logic [DATA_W-1:0] fft_d2_real,
  input  logic [DATA_W-1:0] fft_d2_imag,
  input  logic [DATA_W-1:0] fft_d3_real,
  input  logic [DATA_W-1:0] fft_d3_imag,
  input  logic [DATA_W-1:0] fft_d4_real,
  input  logic [DATA_W-1:0] fft_d4_imag,
  input  logic [DATA_W-1:0] fft_d5_real,
  input  logic [DATA_W-1:0] fft_d5_imag,
  input  logic [DATA_W-1:0] fft_d6_real,
  input  logic [DATA_W-1:0] fft_d6_imag,
  input  logic [DATA_W-1:0] fft_d7_real,
  input  logic [DATA_W-1:0] fft_d7_imag,
  input  logic [DATA_W-1:0] fft_d8_real,
  input  logic [DATA_W-1:0] fft_d8_imag,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [2:0]        out_index,
  output logic              out_last,
  output logic              frame_done,
  output logic              overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  // Rounding constant: half an LSB of the scaled result.
  localparam logic signed [DATA_W:0] ROUND_C = {{DATA_W{1'b0}}, 1'b1} << (SHIFT - 1);

  state_t            state_reg, state_next;
  logic [2:0]        p_reg, p_next;
  logic              frame_done_reg, frame_done_next;
  logic              overrun_reg, overrun_next;
  logic              capture;
  logic [2:0]        rd_idx;
  logic [DATA_W-1:0] in_re [8];
  logic [DATA_W-1:0] in_im [8];
  logic [DATA_W-1:0] buf_re_reg [8];
  logic [DATA_W-1:0] buf_im_reg [8];

  // Round-half-up then arithmetic shift; the extra sum bit avoids overflow and
  // the final truncation back to DATA_W bits cannot lose information.
  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] x);
    logic signed [DATA_W:0] s;
    s = $signed({x[DATA_W-1], x}) + ROUND_C;
    return DATA_W'(s >>> SHIFT);
  endfunction

  assign in_re[0] = fft_d1_real;  assign in_im[0] = fft_d1_imag;
  assign in_re[1] = fft_d2_real;  assign in_im[1] = fft_d2_imag;
  assign in_re[2] = fft_d3_real;  assign in_im[2] = fft_d3_imag;
  assign in_re[3] = fft_d4_real;  assign in_im[3] = fft_d4_imag;
  assign in_re[4] = fft_d5_real;  assign in_im[4] = fft_d5_imag;
  assign in_re[5] = fft_d6_real;  assign in_im[5] = fft_d6_imag;
  assign in_re[6] = fft_d7_real;  assign in_im[6] = fft_d7_imag;
  assign in_re[7] = fft_d8_real;  assign in_im[7] = fft_d8_imag;

  // Frame buffer: each slot loads its scaled input on capture.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_buf
      // Buffer slot register, zeroed on reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          buf_re_reg[gi] <= '0;
          buf_im_reg[gi] <= '0;
        end else if (capture) begin
          buf_re_reg[gi] <= scale(in_re[gi]);
          buf_im_reg[gi] <= scale(in_im[gi]);
        end
      end
    end
  endgenerate

  // State, beat counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      p_reg          <= 3'd0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      p_reg          <= p_next;
      frame_done_reg <= frame_done_next;
      overrun_reg    <= overrun_next;
    end
  end

  // Next-state logic: a strobe is taken in IDLE or alongside the accepted
  // bin-7 beat, which gives back-to-back frames with no bubble.
  always_comb begin
    state_next      = state_reg;
    p_next          = p_reg;
    frame_done_next = 1'b0;
    overrun_next    = overrun_reg;
    capture         = 1'b0;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (butterfly3_done) begin
          capture    = 1'b1;
          p_next     = 3'd0;
          state_next = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (p_reg != 3'd7) begin
            p_next = p_reg + 3'd1;
          end else begin
            frame_done_next = 1'b1;
            in_ready        = 1'b1;
            p_next          = 3'd0;
            if (butterfly3_done) begin
              capture = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (butterfly3_done && !in_ready) begin
      overrun_next = 1'b1;
    end
  end

  // Beat p reads slot bitrev3(p); outputs come only from registers, never from
  // out_ready, so they hold steady during a stall.
  assign rd_idx     = {p_reg[0], p_reg[1], p_reg[2]};
  assign out_real   = out_valid ? buf_re_reg[rd_idx] : '0;
  assign out_imag   = out_valid ? buf_im_reg[rd_idx] : '0;
  assign out_index  = out_valid ? p_reg : 3'd0;
  assign out_last   = out_valid && (p_reg == 3'd7);
  assign frame_done = frame_done_reg;
  assign overrun    = overrun_reg;

endmodule
